board_input: RTL
================

// Module: board_input
// PURPOSE
//   Input-side conditioning for the board's switches and buttons.
//   - Synchronises the raw sw/swb pins into clk.
//   - Debounces them and emits clean levels plus one-cycle press/release pulses.
//   Sits between the pins and all consumers (display enable, data entry), so no
//   logic ever clocks on a raw button (no "posedge |swb" anywhere).
// PARAMETERS
//   NBTN             6          number of push buttons
//   NSW              32         number of slide switches
//   SYNC_STAGES      2          synchroniser flops per input (>=2)
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable clk cycles required (10 ms @ 100 MHz); >=1
// PORTS
//   clk          in   1     system clock; all logic on posedge
//   rst_n        in   1     asynchronous, active-low reset
//   swb          in   NBTN  raw buttons, 1 = pressed, asynchronous to clk
//   sw           in   NSW   raw switches, asynchronous to clk
//   btn_level    out  NBTN  debounced button state
//   btn_press    out  NBTN  1-cycle pulse on debounced 0->1
//   btn_release  out  NBTN  1-cycle pulse on debounced 1->0
//   any_press    out  1     OR of btn_press (drop-in display-enable toggle)
//   sw_stable    out  NSW   debounced switch bus
//   sw_changed   out  1     1-cycle pulse when sw_stable takes a new value
// BEHAVIOUR
//   Reset (rst_n=0, async)
//   - All synchroniser flops, counters and outputs clear to 0; all button FSMs go to LO.
//   - Reset release is not allowed to generate pulses: inputs already high at release
//     debounce normally and then give one btn_press.
//   Synchroniser
//   - s = raw delayed through SYNC_STAGES flops.
//   Per-button FSM (states LO, LO_CHK, HI, HI_CHK; counter width $clog2(DEBOUNCE_CYCLES+1))
//   - LO:     s=1 -> LO_CHK, cnt<=1.
//   - LO_CHK: s=0 -> LO, cnt<=0.
//             s=1 and cnt<DEBOUNCE_CYCLES -> cnt++.
//             s=1 and cnt==DEBOUNCE_CYCLES -> HI, level<=1, press<=1, cnt<=0.
//   - HI / HI_CHK: mirror of the above; the exit into LO sets release<=1.
//   - DEBOUNCE_CYCLES=1: the state changes after one cycle of disagreement.
//   - Any glitch shorter than DEBOUNCE_CYCLES returns to the idle state with no output change.
//   - Latency: raw edge to level/pulse = SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk edges.
//   - press/release are registered together with the level change, high for exactly 1 cycle.
//   - press and release are never high together for the same button.
//   - Buttons are independent: simultaneous presses give simultaneous pulses.
//   Switch bus
//   - One shared counter; the synchronised bus is compared with its previous-cycle value.
//   - Any bit differs -> cnt<=0.
//   - Bus unchanged for DEBOUNCE_CYCLES consecutive cycles and bus != sw_stable
//     -> sw_stable<=bus, sw_changed<=1 for 1 cycle, cnt<=0.
//   - cnt saturates at DEBOUNCE_CYCLES, so no wrap-around.
//   - Bus returning to its old value before the count completes -> no update, no pulse.
//   Reset mid-debounce
//   - Counters are discarded; the input re-qualifies from zero after release.
// TESTING (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//   1. Reset, then swb[1]=1 held
//      -> btn_level[1] rises 7 cycles after the edge;
//      -> btn_press[1] and any_press high exactly 1 cycle; no other outputs change.
//   2. swb[2] bounces 1,0,1,0 (1 cycle each), then 1 held
//      -> a single btn_press[2], 7 cycles after the final rising edge.
//   3. Release swb[1] after case 1
//      -> btn_release[1] 1 cycle, level 0, no btn_press.
//   4. All 6 buttons pressed in the same cycle
//      -> all btn_press bits pulse together; any_press is a single 1-cycle pulse.
//   5. sw=32'hDEADBEEF, changed again to 32'h12345678 after 2 cycles and then held
//      -> sw_stable goes 0 -> 32'h12345678 directly; one sw_changed pulse.
//   6. rst_n low during case 1's count (cycle 5)
//      -> outputs 0 at once; after release, a held button presses 7 cycles later.

Source files
------------

// File: rtl/board_input.sv
// board_input: input conditioning for the board's push buttons and slide switches.
// Raw pins are synchronised into clk and debounced. The outputs are clean levels,
// one-cycle press/release pulses per button, and a debounced switch bus with a
// change pulse. Consumers use these outputs and never clock on a raw pin.
//
// Per-button debounce FSM:
//   state  | meaning
//   LO     | debounced level 0, synchronised input agrees
//   LO_CHK | level 0, input has read 1 for cnt consecutive cycles
//   HI     | debounced level 1, synchronised input agrees
//   HI_CHK | level 1, input has read 0 for cnt consecutive cycles
module board_input #(
  parameter int NBTN            = 6,
  parameter int NSW             = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] swb,
  input  logic [NSW-1:0]  sw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic            any_press,
  output logic [NSW-1:0]  sw_stable,
  output logic            sw_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    LO     = 2'd0,
    LO_CHK = 2'd1,
    HI     = 2'd2,
    HI_CHK = 2'd3
  } btn_state_t;

  // Synchroniser chains; index 0 samples the pin, the top index is the clean copy.
  logic [SYNC_STAGES-1:0][NBTN-1:0] btn_sync;
  logic [SYNC_STAGES-1:0][NSW-1:0]  sw_sync;
  logic [NBTN-1:0]                  btn_s;
  logic [NSW-1:0]                   sw_bus;

  // Shift the raw pins through the synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= '0;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], swb};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw};
    end
  end

  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign sw_bus = sw_sync[SYNC_STAGES-1];

  // One independent debounce FSM per button.
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          prs;
    logic          rel;
    logic          s;

    assign s = btn_s[i];

    // Qualify a level change only after the input disagrees for long enough;
    // the pulses are registered in the same cycle as the level change.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= LO;
        cnt   <= '0;
        lvl   <= 1'b0;
        prs   <= 1'b0;
        rel   <= 1'b0;
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        case (state)
          LO: begin
            if (s) begin
              state <= LO_CHK;
              cnt   <= CNT_ONE;
            end
          end
          LO_CHK: begin
            if (!s) begin
              state <= LO;
              cnt   <= '0;
            end else if (cnt == CNT_DONE) begin
              state <= HI;
              lvl   <= 1'b1;
              prs   <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HI: begin
            if (!s) begin
              state <= HI_CHK;
              cnt   <= CNT_ONE;
            end
          end
          HI_CHK: begin
            if (s) begin
              state <= HI;
              cnt   <= '0;
            end else if (cnt == CNT_DONE) begin
              state <= LO;
              lvl   <= 1'b0;
              rel   <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= LO;
            cnt   <= '0;
            lvl   <= 1'b0;
          end
        endcase
      end
    end

    assign btn_level[i]   = lvl;
    assign btn_press[i]   = prs;
    assign btn_release[i] = rel;
  end

  assign any_press = |btn_press;

  // Switch bus: one shared counter. Any bit moving restarts the count; the count
  // saturates, so a bus that settles back to sw_stable never produces a pulse.
  logic [NSW-1:0] sw_prev;
  logic [CW-1:0]  sw_cnt;
  logic [NSW-1:0] sw_stable_q;
  logic           sw_changed_q;

  // Track stability of the synchronised bus and latch a new value once qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_prev      <= '0;
      sw_cnt       <= '0;
      sw_stable_q  <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_changed_q <= 1'b0;
      sw_prev      <= sw_bus;
      if (sw_bus != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt == CNT_DONE) begin
        if (sw_bus != sw_stable_q) begin
          sw_stable_q  <= sw_bus;
          sw_changed_q <= 1'b1;
          sw_cnt       <= '0;
        end
      end else begin
        sw_cnt <= sw_cnt + 1'b1;
      end
    end
  end

  assign sw_stable  = sw_stable_q;
  assign sw_changed = sw_changed_q;

endmodule
